// File: rtl/des_pkg.sv
// Shared types and constants for the DES round scheduler: FSM states, round
// count and the per-round key-half rotate table for the encrypt direction.
package des_pkg;

  localparam int ROUNDS = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_RESP  = 3'd4
  } des_state_e;

  // Entry [i] is the encrypt rotate amount for round i (element 0 is rightmost).
  localparam logic [15:0][1:0] ENC_SHIFT = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

  function automatic logic [1:0] enc_shift(input logic [3:0] idx);
    return ENC_SHIFT[idx];
  endfunction

endpackage

// File: rtl/des_rr_arb.sv
// NREQ-way round-robin arbiter: combinational one-hot grant plus index; the
// pointer remembers the last winner and only moves when advance_i is high.
module des_rr_arb #(
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_i,
  input  logic                     advance_i,
  output logic [NREQ-1:0]          grant_oh_o,
  output logic [$clog2(NREQ)-1:0]  grant_idx_o,
  output logic                     any_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] last_q;
  logic [IW-1:0] cidx;
  int            cand;

  // Search starts one past the last winner; reset value makes requester 0 first.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = 0;
    cidx        = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(last_q) + off) % NREQ;
      cidx = cand[IW-1:0];
      if (!any_o && req_i[cidx]) begin
        any_o            = 1'b1;
        grant_oh_o[cidx] = 1'b1;
        grant_idx_o      = cidx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IW'(NREQ - 1);
    end else if (advance_i) begin
      last_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/des_round_sched.sv
// Time-shares one DES round datapath among NREQ requesters: arbitrate, load,
// 16 rounds, final permutation, then hold the result until taken.
// Decrypt key schedule is built only when DES_SCHED_DECRYPT_EN is defined.
module des_round_sched
  import des_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_decrypt,
  output logic [NREQ-1:0]          req_ready,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     dp_load,
  output logic                     dp_round_en,
  output logic [1:0]               dp_shift_amt,
  output logic                     dp_shift_dir,
  output logic                     dp_final,
  output logic [3:0]               round_idx,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     busy,
  output des_state_e               dbg_state
);

  localparam int IW = $clog2(NREQ);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; ready never depends on rsp_ready, and rsp_valid holds until taken.
  des_state_e     state_q, state_d;
  logic [3:0]     round_q, round_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [NREQ-1:0] arb_oh;
  logic [IW-1:0]  arb_idx;
  logic           arb_any;
  logic           accept;

  assign accept = (state_q == S_IDLE) && arb_any;

  des_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_valid),
    .advance_i   (accept),
    .grant_oh_o  (arb_oh),
    .grant_idx_o (arb_idx),
    .any_o       (arb_any)
  );

`ifdef DES_SCHED_DECRYPT_EN
  logic mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= 1'b0;
    end else if (accept) begin
      mode_q <= req_decrypt[arb_idx];
    end
  end
`else
  logic unused_decrypt;
  assign unused_decrypt = ^req_decrypt;
`endif

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    grant_d      = grant_q;
    req_ready    = '0;
    dp_load      = 1'b0;
    dp_round_en  = 1'b0;
    dp_shift_amt = 2'd0;
    dp_shift_dir = 1'b0;
    dp_final     = 1'b0;
    rsp_valid    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = arb_oh;
        if (arb_any) begin
          state_d = S_LOAD;
          grant_d = arb_idx;
        end
      end
      S_LOAD: begin
        dp_load = 1'b1;
        round_d = 4'd0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        dp_round_en = 1'b1;
`ifdef DES_SCHED_DECRYPT_EN
        // Decrypt rotates right; round 0 needs no rotate, the rest mirror encrypt.
        dp_shift_dir = mode_q;
        dp_shift_amt = (mode_q && round_q == 4'd0) ? 2'd0 : enc_shift(round_q);
`else
        dp_shift_amt = enc_shift(round_q);
`endif
        round_d = round_q + 4'd1;
        if (round_q == 4'(ROUNDS - 1)) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        dp_final = 1'b1;
        state_d  = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      grant_q <= grant_d;
    end
  end

  assign grant_id  = grant_q;
  assign rsp_id    = grant_q;
  assign round_idx = round_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule
